// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out framed transmitter.
// Frame on tx_o: start (0), DATA_W data bits LSB first, optional even parity,
// stop (1). The line idles high. One word is taken per valid/ready handshake,
// and each serial bit is held for CLKS_PER_BIT clock cycles.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    // Counter widths never drop below one bit, so the degenerate
    // CLKS_PER_BIT=1 and DATA_W=1 cases still have a legal register.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cyc_cnt;
    logic              bit_end;

    // Even parity: the bit that makes the ones count over data+parity even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Last clock cycle of the serial bit currently on the line.
    assign bit_end = (cyc_cnt == CNT_LAST);

    // Framing FSM. tx_o and the handshake/status outputs are all flops, so
    // the line never carries decode glitches. Parity is computed once at
    // accept, so it does not depend on the shift register as it drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            tx_o    <= 1'b1;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;

            // Every non-idle state times its bit the same way.
            if (state != S_IDLE) begin
                cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // ready_o is high throughout IDLE, so valid_i alone
                    // completes the handshake here.
                    if (valid_i) begin
                        shift_q <= data_i;
                        par_q   <= even_parity(data_i);
                        bit_cnt <= '0;
                        cyc_cnt <= '0;
                        tx_o    <= 1'b0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        tx_o    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx_o  <= par_q;
                                state <= S_PARITY;
                            end else begin
                                tx_o  <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_o    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        tx_o  <= 1'b1;
                        state <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        tx_o    <= 1'b1;
                        done_o  <= 1'b1;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    tx_o    <= 1'b1;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
